// File: rtl/exception_redirect_pkg.sv
// Shared types and constants for the exception/ERET redirect path:
// exception codes, exception vector addresses and the sequencer state enum.
package exception_redirect_pkg;

    typedef enum logic [4:0] {
        EX_INT  = 5'h00,
        EX_MOD  = 5'h01,
        EX_TLBL = 5'h02,
        EX_TLBS = 5'h03,
        EX_ADEL = 5'h04,
        EX_ADES = 5'h05,
        EX_IBE  = 5'h06,
        EX_DBE  = 5'h07,
        EX_SYS  = 5'h08,
        EX_BP   = 5'h09,
        EX_RI   = 5'h0a,
        EX_CPU  = 5'h0b,
        EX_OV   = 5'h0c,
        EX_TR   = 5'h0d
    } exc_code_t;

    localparam logic [31:0] VEC_GEN      = 32'h8000_0180;
    localparam logic [31:0] VEC_INT      = 32'h8000_0200;
    localparam logic [31:0] VEC_GEN_BOOT = 32'hbfc0_0380;
    localparam logic [31:0] VEC_INT_BOOT = 32'hbfc0_0400;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } redir_state_t;

endpackage

// File: rtl/exception_redirect_vector_sel.sv
// Combinational redirect-target select: exception vector from BEV/IV/code,
// or the ERET return address from EPC / ErrorEPC.
module exc_vector_sel
    import exception_redirect_pkg::*;
(
    input  logic [4:0]  code,
    input  logic        bev,
    input  logic        iv,
    input  logic        eret,
    input  logic        erl,
    input  logic [31:0] epc,
    input  logic [31:0] error_epc,
    output logic [31:0] pc
);

    always_comb begin
        pc = VEC_GEN;
        if (eret) begin
            pc = erl ? error_epc : epc;
        end else if (code == EX_INT) begin
            case ({bev, iv})
                2'b00:   pc = VEC_GEN;
                2'b01:   pc = VEC_INT;
                2'b10:   pc = VEC_GEN_BOOT;
                default: pc = VEC_INT_BOOT;
            endcase
        end else begin
            pc = bev ? VEC_GEN_BOOT : VEC_GEN;
        end
    end

endmodule

// File: rtl/exception_redirect.sv
// Turns committed exceptions/ERETs into a flush-then-redirect sequence toward
// fetch, and registers the interrupt request for the next committing instruction.
module exception_redirect
    import exception_redirect_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic        status_erl,
    input  logic        status_bev,
    input  logic [7:0]  status_im,
    input  logic [7:0]  cause_ip,
    input  logic        cause_iv,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] cp0_error_epc,
    input  logic        commit_valid,
    input  logic        commit_exc,
    input  logic [4:0]  commit_code,
    input  logic        commit_eret,
    output logic        int_req_o,
    output logic        commit_stall_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    redir_state_t   state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    pc_q, pc_d;
    logic           int_req_q, flush_q, redirect_valid_q, stall_q;

    logic           hit;
    logic           accept;
    logic [31:0]    target;

    assign hit    = status_ie & ~status_exl & ~status_erl & (|(cause_ip & status_im));
    assign accept = (state_q == IDLE) & commit_valid & (commit_exc | commit_eret);

    // Exception wins over ERET when both are flagged on the same commit.
    exc_vector_sel u_vec_sel (
        .code      (commit_code),
        .bev       (status_bev),
        .iv        (cause_iv),
        .eret      (commit_eret & ~commit_exc),
        .erl       (status_erl),
        .epc       (cp0_epc),
        .error_epc (cp0_error_epc),
        .pc        (target)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FLUSH;
                    cnt_d   = CW'(FLUSH_CYCLES - 1);
                    pc_d    = target;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = REDIRECT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            pc_q             <= '0;
            int_req_q        <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            stall_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            pc_q             <= pc_d;
            int_req_q        <= hit & (state_d == IDLE);
            flush_q          <= (state_d == FLUSH);
            redirect_valid_q <= (state_d == REDIRECT);
            stall_q          <= (state_d != IDLE);
        end
    end

    assign int_req_o        = int_req_q;
    assign flush_o          = flush_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = pc_q;
    assign commit_stall_o   = stall_q;

endmodule

// File: tb/tb_exception_redirect.sv
// Bench for exception_redirect: directed vector table, hand-written corner
// sequences and random traffic, all compared against a cycle-level reference model.
module tb_exception_redirect;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        status_ie, status_exl, status_erl, status_bev;
    logic [7:0]  status_im, cause_ip;
    logic        cause_iv;
    logic [31:0] cp0_epc, cp0_error_epc;
    logic        commit_valid, commit_exc, commit_eret;
    logic [4:0]  commit_code;
    logic        redirect_ready;
    logic        int_req_o, commit_stall_o, flush_o, redirect_valid_o;
    logic [31:0] redirect_pc_o;

    int checks = 0;
    int errors = 0;
    int accepts = 0;

    // reference model: mode 0 idle, 1 flushing, 2 waiting for fetch
    int          m_mode;
    int          m_left;
    logic [31:0] m_pc;
    logic        m_int;

    exception_redirect #(.FLUSH_CYCLES(FC)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .status_ie        (status_ie),
        .status_exl       (status_exl),
        .status_erl       (status_erl),
        .status_bev       (status_bev),
        .status_im        (status_im),
        .cause_ip         (cause_ip),
        .cause_iv         (cause_iv),
        .cp0_epc          (cp0_epc),
        .cp0_error_epc    (cp0_error_epc),
        .commit_valid     (commit_valid),
        .commit_exc       (commit_exc),
        .commit_code      (commit_code),
        .commit_eret      (commit_eret),
        .int_req_o        (int_req_o),
        .commit_stall_o   (commit_stall_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready   (redirect_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic        ie, exl, erl, bev;
        logic [7:0]  im, ip;
        logic        iv, cv, exc;
        logic [4:0]  code;
        logic        eret, rdy;
        logic        e_int, e_stall, e_flush, e_rv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [31:0] ref_target(logic exc, logic [4:0] code, logic bev, logic iv,
                                               logic erl, logic [31:0] epc, logic [31:0] eepc);
        if (!exc) return erl ? eepc : epc;
        if (code == 5'd0) begin
            if (!bev && !iv) return 32'h8000_0180;
            if (!bev &&  iv) return 32'h8000_0200;
            if ( bev && !iv) return 32'hbfc0_0380;
            return 32'hbfc0_0400;
        end
        return bev ? 32'hbfc0_0380 : 32'h8000_0180;
    endfunction

    task automatic model_edge();
        logic hit;
        hit = status_ie && !status_exl && !status_erl && ((cause_ip & status_im) != 8'h00);
        if (!resetn) begin
            m_mode = 0; m_left = 0; m_pc = 32'h0; m_int = 1'b0;
            return;
        end
        if (m_mode == 0) begin
            if (commit_valid && (commit_exc || commit_eret)) begin
                m_pc   = ref_target(commit_exc, commit_code, status_bev, cause_iv,
                                    status_erl, cp0_epc, cp0_error_epc);
                m_mode = 1;
                m_left = FC;
            end
        end else if (m_mode == 1) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 2;
        end else begin
            if (redirect_ready) m_mode = 0;
        end
        m_int = hit && (m_mode == 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        if (redirect_valid_o === 1'b1 && redirect_ready === 1'b1 && resetn === 1'b1) accepts++;
        @(posedge clk);
        model_edge();
        #1;
        chk("model_int",   32'(int_req_o),        32'(m_int));
        chk("model_flush", 32'(flush_o),          32'(m_mode == 1));
        chk("model_rv",    32'(redirect_valid_o), 32'(m_mode == 2));
        chk("model_stall", 32'(commit_stall_o),   32'(m_mode != 0));
        chk("model_pc",    redirect_pc_o,         m_pc);
    endtask

    task automatic idle_inputs();
        resetn = 1'b1;
        status_ie = 0; status_exl = 0; status_erl = 0; status_bev = 0;
        status_im = 8'h00; cause_ip = 8'h00; cause_iv = 0;
        commit_valid = 0; commit_exc = 0; commit_code = 5'd0; commit_eret = 0;
        redirect_ready = 0;
    endtask

    function automatic vec_t mk(logic rst_n, logic ie, logic exl, logic bev, logic [7:0] im,
                                logic [7:0] ip, logic iv, logic cv, logic exc, logic [4:0] code,
                                logic rdy, logic e_int, logic e_stall, logic e_flush, logic e_rv,
                                logic [31:0] e_pc);
        vec_t v;
        v.rst_n = rst_n; v.ie = ie; v.exl = exl; v.erl = 1'b0; v.bev = bev;
        v.im = im; v.ip = ip; v.iv = iv; v.cv = cv; v.exc = exc; v.code = code;
        v.eret = 1'b0; v.rdy = rdy;
        v.e_int = e_int; v.e_stall = e_stall; v.e_flush = e_flush; v.e_rv = e_rv; v.e_pc = e_pc;
        return v;
    endfunction

    initial begin
        // Reset with everything at 1, release, syscall with slow fetch, then interrupt.
        //           rst ie exl bev im     ip     iv cv exc code  rdy  int stl fl rv pc
        tbl[0]  = mk(0, 1, 1, 1, 8'hff, 8'hff, 1, 1, 1, 5'h1f, 1,   0, 0, 0, 0, 32'h0);
        tbl[1]  = mk(0, 1, 1, 1, 8'hff, 8'hff, 1, 1, 1, 5'h1f, 1,   0, 0, 0, 0, 32'h0);
        tbl[2]  = mk(0, 1, 1, 1, 8'hff, 8'hff, 1, 1, 1, 5'h1f, 1,   0, 0, 0, 0, 32'h0);
        tbl[3]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 5'h00, 0,   0, 0, 0, 0, 32'h0);
        tbl[4]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 5'h00, 0,   0, 0, 0, 0, 32'h0);
        tbl[5]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 1, 5'h08, 0,   0, 1, 1, 0, 32'h8000_0180);
        tbl[6]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 5'h00, 0,   0, 1, 1, 0, 32'h8000_0180);
        tbl[7]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 5'h00, 0,   0, 1, 0, 1, 32'h8000_0180);
        tbl[8]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 5'h00, 0,   0, 1, 0, 1, 32'h8000_0180);
        tbl[9]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 5'h00, 0,   0, 1, 0, 1, 32'h8000_0180);
        tbl[10] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 5'h00, 0,   0, 1, 0, 1, 32'h8000_0180);
        tbl[11] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 5'h00, 1,   0, 0, 0, 0, 32'h8000_0180);
        tbl[12] = mk(1, 1, 0, 0, 8'h80, 8'h80, 0, 0, 0, 5'h00, 0,   1, 0, 0, 0, 32'h8000_0180);
        tbl[13] = mk(1, 1, 0, 0, 8'h80, 8'h80, 1, 1, 1, 5'h00, 0,   0, 1, 1, 0, 32'h8000_0200);
        tbl[14] = mk(1, 1, 0, 0, 8'h80, 8'h80, 1, 0, 0, 5'h00, 0,   0, 1, 1, 0, 32'h8000_0200);
        tbl[15] = mk(1, 1, 0, 0, 8'h80, 8'h80, 1, 0, 0, 5'h00, 1,   0, 1, 0, 1, 32'h8000_0200);
        tbl[16] = mk(1, 1, 0, 0, 8'h80, 8'h80, 1, 0, 0, 5'h00, 1,   1, 0, 0, 0, 32'h8000_0200);
        tbl[17] = mk(1, 1, 1, 0, 8'h80, 8'h80, 1, 0, 0, 5'h00, 0,   0, 0, 0, 0, 32'h8000_0200);

        idle_inputs();
        cp0_epc = 32'h8000_1000;
        cp0_error_epc = 32'hbfc0_0100;
        m_mode = 0; m_left = 0; m_pc = 32'h0; m_int = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            resetn = tbl[i].rst_n;
            status_ie = tbl[i].ie; status_exl = tbl[i].exl; status_erl = tbl[i].erl;
            status_bev = tbl[i].bev; status_im = tbl[i].im; cause_ip = tbl[i].ip;
            cause_iv = tbl[i].iv; commit_valid = tbl[i].cv; commit_exc = tbl[i].exc;
            commit_code = tbl[i].code; commit_eret = tbl[i].eret; redirect_ready = tbl[i].rdy;
            tick();
            chk($sformatf("tbl%0d_int", i),   32'(int_req_o),        32'(tbl[i].e_int));
            chk($sformatf("tbl%0d_stall", i), 32'(commit_stall_o),   32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_flush", i), 32'(flush_o),          32'(tbl[i].e_flush));
            chk($sformatf("tbl%0d_rv", i),    32'(redirect_valid_o), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_pc", i),    redirect_pc_o,         tbl[i].e_pc);
        end

        // ERET with ERL=1 then ERL=0
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            status_erl = (k == 0);
            commit_valid = 1; commit_eret = 1;
            tick();
            idle_inputs();
            tick(); tick();
            chk("eret_rv", 32'(redirect_valid_o), 32'd1);
            chk("eret_pc", redirect_pc_o, (k == 0) ? 32'hbfc0_0100 : 32'h8000_1000);
            redirect_ready = 1;
            tick();
            idle_inputs();
        end

        // exception + ERET together; a second exception during FLUSH is ignored
        accepts = 0;
        idle_inputs();
        status_bev = 1; commit_valid = 1; commit_exc = 1; commit_eret = 1; commit_code = 5'd4;
        tick();
        commit_eret = 0; commit_code = 5'd8; status_bev = 0;
        tick();
        chk("dual_pc", redirect_pc_o, 32'hbfc0_0380);
        idle_inputs();
        tick();
        redirect_ready = 1;
        for (int c = 0; c < 4; c++) tick();
        chk("dual_one_redirect", 32'(accepts), 32'd1);
        chk("dual_back_idle", 32'(commit_stall_o), 32'd0);

        // reset during REDIRECT aborts; EXL masks a pending interrupt
        idle_inputs();
        commit_valid = 1; commit_exc = 1; commit_code = 5'd12;
        tick();
        idle_inputs();
        tick(); tick();
        chk("pre_abort_rv", 32'(redirect_valid_o), 32'd1);
        resetn = 0;
        tick();
        chk("abort_rv", 32'(redirect_valid_o), 32'd0);
        chk("abort_stall", 32'(commit_stall_o), 32'd0);
        idle_inputs();
        status_ie = 1; status_exl = 1; status_im = 8'hff; cause_ip = 8'h04;
        tick(); tick();
        chk("exl_masks_int", 32'(int_req_o), 32'd0);
        status_exl = 0;
        tick();
        chk("int_after_exl", 32'(int_req_o), 32'd1);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            resetn        = ($urandom_range(99) >= 2);
            status_ie     = $urandom_range(1);
            status_exl    = ($urandom_range(3) == 0);
            status_erl    = ($urandom_range(3) == 0);
            status_bev    = $urandom_range(1);
            status_im     = 8'($urandom);
            cause_ip      = 8'($urandom) & 8'($urandom);
            cause_iv      = $urandom_range(1);
            cp0_epc       = $urandom;
            cp0_error_epc = $urandom;
            commit_valid  = ($urandom_range(9) < 3);
            commit_exc    = $urandom_range(1);
            commit_eret   = ($urandom_range(9) < 3);
            commit_code   = ($urandom_range(1) == 1) ? 5'd0 : 5'($urandom_range(13));
            redirect_ready = ($urandom_range(9) < 4);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
